// File: rtl/video_ports_ml.sv
// Video-mode register file written through one addressed bus: line/frame shadow
// latching, atomic 16-bit scroll commits and an auto-advancing vertical interrupt line.
module video_ports_ml #(
  parameter int NUM_TLAYERS     = 2,
  parameter int OFFS_W          = 9,
  parameter int LINES_PER_FRAME = 320
) (
  input  logic                          clk,
  input  logic                          res_n,
  input  logic                          wr,
  input  logic [5:0]                    addr,
  input  logic [7:0]                    d,
  input  logic                          line_start_s,
  input  logic                          int_start,
  output logic [7:0]                    border,
  output logic [7:0]                    vpage,
  output logic [7:0]                    vconf,
  output logic [7:0]                    palsel,
  output logic [7:0]                    tsconf,
  output logic [7:0]                    tmpage,
  output logic [7:0]                    sgpage,
  output logic [7:0]                    hint_beg,
  output logic [8:0]                    vint_beg,
  output logic [OFFS_W-1:0]             gx_offs,
  output logic [OFFS_W-1:0]             gy_offs,
  output logic [NUM_TLAYERS*OFFS_W-1:0] tx_offs,
  output logic [NUM_TLAYERS*OFFS_W-1:0] ty_offs,
  output logic [NUM_TLAYERS*8-1:0]      tgpage,
  output logic                          frame_mode,
  output logic                          shadow_pend
);
  localparam int         HW  = OFFS_W - 8;
  localparam logic [9:0] LPF = 10'(LINES_PER_FRAME);

  localparam logic [5:0] A_BORDER  = 6'h00;
  localparam logic [5:0] A_ZBORDER = 6'h01;
  localparam logic [5:0] A_VPAGE   = 6'h02;
  localparam logic [5:0] A_ZVPAGE  = 6'h03;
  localparam logic [5:0] A_VCONF   = 6'h04;
  localparam logic [5:0] A_PALSEL  = 6'h05;
  localparam logic [5:0] A_TSCONF  = 6'h06;
  localparam logic [5:0] A_TMPAGE  = 6'h07;
  localparam logic [5:0] A_SGPAGE  = 6'h08;
  localparam logic [5:0] A_HINT    = 6'h09;
  localparam logic [5:0] A_VINT_L  = 6'h0A;
  localparam logic [5:0] A_VINT_H  = 6'h0B;
  localparam logic [5:0] A_GX_L    = 6'h0C;
  localparam logic [5:0] A_GX_H    = 6'h0D;
  localparam logic [5:0] A_GY_L    = 6'h0E;
  localparam logic [5:0] A_GY_H    = 6'h0F;
  localparam logic [5:0] A_LCTL    = 6'h10;
  localparam logic [5:0] A_TGPAGE  = 6'h30;

  typedef logic [OFFS_W-1:0] offs_t;

  logic [7:0] border_q, border_d, vpage_q, vpage_d, vconf_q, vconf_d, palsel_q, palsel_d;
  logic [7:0] tsconf_q, tsconf_d, tmpage_q, tmpage_d, sgpage_q, sgpage_d, hint_q, hint_d;
  logic [7:0] vpage_sh_q, vpage_sh_d, vconf_sh_q, vconf_sh_d, palsel_sh_q, palsel_sh_d;
  logic [8:0] vint_q, vint_d;
  logic [3:0] vinc_q, vinc_d;
  logic [1:0] lctl_q, lctl_d;
  logic       pend_q, pend_d;
  offs_t      gx_q, gx_d, gx_sh_q, gx_sh_d, gy_q, gy_d;
  logic [7:0] gx_hold_q, gx_hold_d, gy_hold_q, gy_hold_d;
  offs_t      tx_q [NUM_TLAYERS];
  offs_t      tx_d [NUM_TLAYERS];
  offs_t      tx_sh_q [NUM_TLAYERS];
  offs_t      tx_sh_d [NUM_TLAYERS];
  offs_t      ty_q [NUM_TLAYERS];
  offs_t      ty_d [NUM_TLAYERS];
  logic [7:0] tx_hold_q [NUM_TLAYERS];
  logic [7:0] tx_hold_d [NUM_TLAYERS];
  logic [7:0] ty_hold_q [NUM_TLAYERS];
  logic [7:0] ty_hold_d [NUM_TLAYERS];
  logic [7:0] tg_q [NUM_TLAYERS];
  logic [7:0] tg_d [NUM_TLAYERS];
  logic [7:0] tg_sh_q [NUM_TLAYERS];
  logic [7:0] tg_sh_d [NUM_TLAYERS];

  logic       latch_ev_s, atomic_s, sh_wr_s, vint_wr_s;
  logic [9:0] vsum_s;
  logic [8:0] vnext_s;

  // Next-state: latch event first (pre-write shadows), then the bus write on top.
  always_comb begin
    latch_ev_s = lctl_q[0] ? int_start : line_start_s;
    atomic_s   = lctl_q[1];
    vint_wr_s  = wr && ((addr == A_VINT_L) || (addr == A_VINT_H));
    vsum_s     = {1'b0, vint_q} + {6'd0, vinc_q};
    vnext_s    = (vsum_s >= LPF) ? 9'(vsum_s - LPF) : vsum_s[8:0];
    sh_wr_s    = 1'b0;

    border_d    = border_q;
    tsconf_d    = tsconf_q;
    tmpage_d    = tmpage_q;
    sgpage_d    = sgpage_q;
    hint_d      = hint_q;
    vinc_d      = vinc_q;
    lctl_d      = lctl_q;
    gy_d        = gy_q;
    gx_hold_d   = gx_hold_q;
    gy_hold_d   = gy_hold_q;
    vpage_sh_d  = vpage_sh_q;
    vconf_sh_d  = vconf_sh_q;
    palsel_sh_d = palsel_sh_q;
    gx_sh_d     = gx_sh_q;
    vpage_d     = latch_ev_s ? vpage_sh_q  : vpage_q;
    vconf_d     = latch_ev_s ? vconf_sh_q  : vconf_q;
    palsel_d    = latch_ev_s ? palsel_sh_q : palsel_q;
    gx_d        = latch_ev_s ? gx_sh_q     : gx_q;
    vint_d      = (int_start && !vint_wr_s) ? vnext_s : vint_q;
    for (int n = 0; n < NUM_TLAYERS; n++) begin
      tx_d[n]      = latch_ev_s ? tx_sh_q[n] : tx_q[n];
      tg_d[n]      = latch_ev_s ? tg_sh_q[n] : tg_q[n];
      tx_sh_d[n]   = tx_sh_q[n];
      tg_sh_d[n]   = tg_sh_q[n];
      ty_d[n]      = ty_q[n];
      tx_hold_d[n] = tx_hold_q[n];
      ty_hold_d[n] = ty_hold_q[n];
    end

    if (wr) begin
      case (addr)
        A_BORDER:  border_d = d;
        A_ZBORDER: border_d = {palsel_q[3:0], 1'b0, d[2:0]};
        A_VPAGE:   begin vpage_sh_d = d; sh_wr_s = 1'b1; end
        A_ZVPAGE:  begin
          vpage_sh_d = {6'b000001, d[3], 1'b1};
          vpage_d    = {6'b000001, d[3], 1'b1};
          sh_wr_s    = 1'b1;
        end
        A_VCONF:   begin vconf_sh_d = d; sh_wr_s = 1'b1; end
        A_PALSEL:  begin palsel_sh_d = d; sh_wr_s = 1'b1; end
        A_TSCONF:  tsconf_d = d;
        A_TMPAGE:  tmpage_d = d;
        A_SGPAGE:  sgpage_d = d;
        A_HINT:    hint_d = d;
        A_VINT_L:  vint_d = {vint_q[8], d};
        A_VINT_H:  begin vint_d = {d[0], vint_q[7:0]}; vinc_d = d[7:4]; end
        A_GX_L:    begin
          if (atomic_s) begin
            gx_hold_d = d;
          end else begin
            gx_sh_d = {gx_sh_q[OFFS_W-1:8], d};
            sh_wr_s = 1'b1;
          end
        end
        A_GX_H:    begin
          gx_sh_d = {d[HW-1:0], atomic_s ? gx_hold_q : gx_sh_q[7:0]};
          sh_wr_s = 1'b1;
        end
        A_GY_L:    begin
          if (atomic_s) gy_hold_d = d;
          else          gy_d = {gy_q[OFFS_W-1:8], d};
        end
        A_GY_H:    gy_d = {d[HW-1:0], atomic_s ? gy_hold_q : gy_q[7:0]};
        A_LCTL:    lctl_d = d[1:0];
        default: begin
          // Layer blocks and tgpage slots beyond NUM_TLAYERS match nothing here.
          for (int n = 0; n < NUM_TLAYERS; n++) begin
            if ((addr[5:4] == 2'b10) && (addr[3:2] == 2'(n))) begin
              case (addr[1:0])
                2'd0: begin
                  if (atomic_s) begin
                    tx_hold_d[n] = d;
                  end else begin
                    tx_sh_d[n] = {tx_sh_q[n][OFFS_W-1:8], d};
                    sh_wr_s    = 1'b1;
                  end
                end
                2'd1: begin
                  tx_sh_d[n] = {d[HW-1:0], atomic_s ? tx_hold_q[n] : tx_sh_q[n][7:0]};
                  sh_wr_s    = 1'b1;
                end
                2'd2: begin
                  if (atomic_s) ty_hold_d[n] = d;
                  else          ty_d[n] = {ty_q[n][OFFS_W-1:8], d};
                end
                2'd3:    ty_d[n] = {d[HW-1:0], atomic_s ? ty_hold_q[n] : ty_q[n][7:0]};
                default: ty_d[n] = ty_q[n];
              endcase
            end else if (addr == (A_TGPAGE + 6'(n))) begin
              tg_sh_d[n] = d;
              sh_wr_s    = 1'b1;
            end else begin
              tg_sh_d[n] = tg_sh_q[n];
            end
          end
        end
      endcase
    end else begin
      sh_wr_s = 1'b0;
    end

    pend_d = sh_wr_s ? 1'b1 : (latch_ev_s ? 1'b0 : pend_q);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      border_q    <= 8'h00;
      vpage_q     <= 8'h05;
      vconf_q     <= 8'h00;
      palsel_q    <= 8'h0F;
      tsconf_q    <= 8'h00;
      tmpage_q    <= 8'h00;
      sgpage_q    <= 8'h00;
      hint_q      <= 8'h01;
      vpage_sh_q  <= 8'h05;
      vconf_sh_q  <= 8'h00;
      palsel_sh_q <= 8'h0F;
      vint_q      <= 9'd0;
      vinc_q      <= 4'd0;
      lctl_q      <= 2'd0;
      pend_q      <= 1'b0;
      gx_q        <= '0;
      gx_sh_q     <= '0;
      gy_q        <= '0;
      gx_hold_q   <= 8'h00;
      gy_hold_q   <= 8'h00;
      for (int n = 0; n < NUM_TLAYERS; n++) begin
        tx_q[n]      <= '0;
        tx_sh_q[n]   <= '0;
        ty_q[n]      <= '0;
        tx_hold_q[n] <= 8'h00;
        ty_hold_q[n] <= 8'h00;
        tg_q[n]      <= 8'h00;
        tg_sh_q[n]   <= 8'h00;
      end
    end else begin
      border_q    <= border_d;
      vpage_q     <= vpage_d;
      vconf_q     <= vconf_d;
      palsel_q    <= palsel_d;
      tsconf_q    <= tsconf_d;
      tmpage_q    <= tmpage_d;
      sgpage_q    <= sgpage_d;
      hint_q      <= hint_d;
      vpage_sh_q  <= vpage_sh_d;
      vconf_sh_q  <= vconf_sh_d;
      palsel_sh_q <= palsel_sh_d;
      vint_q      <= vint_d;
      vinc_q      <= vinc_d;
      lctl_q      <= lctl_d;
      pend_q      <= pend_d;
      gx_q        <= gx_d;
      gx_sh_q     <= gx_sh_d;
      gy_q        <= gy_d;
      gx_hold_q   <= gx_hold_d;
      gy_hold_q   <= gy_hold_d;
      for (int n = 0; n < NUM_TLAYERS; n++) begin
        tx_q[n]      <= tx_d[n];
        tx_sh_q[n]   <= tx_sh_d[n];
        ty_q[n]      <= ty_d[n];
        tx_hold_q[n] <= tx_hold_d[n];
        ty_hold_q[n] <= ty_hold_d[n];
        tg_q[n]      <= tg_d[n];
        tg_sh_q[n]   <= tg_sh_d[n];
      end
    end
  end

  assign border      = border_q;
  assign vpage       = vpage_q;
  assign vconf       = vconf_q;
  assign palsel      = palsel_q;
  assign tsconf      = tsconf_q;
  assign tmpage      = tmpage_q;
  assign sgpage      = sgpage_q;
  assign hint_beg    = hint_q;
  assign vint_beg    = vint_q;
  assign gx_offs     = gx_q;
  assign gy_offs     = gy_q;
  assign frame_mode  = lctl_q[0];
  assign shadow_pend = pend_q;

  for (genvar n = 0; n < NUM_TLAYERS; n++) begin : g_pack
    assign tx_offs[n*OFFS_W +: OFFS_W] = tx_q[n];
    assign ty_offs[n*OFFS_W +: OFFS_W] = ty_q[n];
    assign tgpage[n*8 +: 8]            = tg_q[n];
  end

endmodule
